// File: rtl/mem_pkg.sv
// Shared MEM definitions: setting width, the printable-letter bounds, and the letter test
// that decides whether a byte steps the key sequence.
package mem_pkg;

  localparam int SETTING_W = 2;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/mem_stream_decryptor_mem.sv
// Combinational MEM mapping: each setting selects a fixed-point-free letter pairing, so
// applying the same setting twice returns the original letter. Non-letters pass unchanged.
module mem_stream_decryptor_mem
  import mem_pkg::*;
(
  output logic [7:0]           out,
  input  logic [7:0]           in,
  input  logic [SETTING_W-1:0] setting
);

  // Row = setting 00..11, column = letter A..Z, entry = partner letter
  localparam logic [0:3][0:25][7:0] MAP = {
    "OCBEDGFIHKJYNMAQPSRUTWVZLX",
    "BADCSGFIHLWJNMPORQEUTXKVZY",
    "BAHLFEOCJIMDKPGNRQTSVUXWZY",
    "BADCFEIRGKJQNMPOLHTSVUXWZY"
  };

  logic [4:0] idx_s;

  assign idx_s = 5'(in - ASCII_A);

  // Table lookup for letters, identity for everything else
  always_comb begin
    out = in;
    if (is_alpha(in)) begin
      out = MAP[setting][idx_s];
    end else begin
      out = in;
    end
  end

endmodule

// File: rtl/mem_stream_decryptor.sv
// Streaming MEM decryptor: steps a 2-bit setting through a loaded key per accepted letter.
// Optional macro MEM_DEC_NONALPHA_PASS_EN forwards non-letters instead of dropping them.
module mem_stream_decryptor
  import mem_pkg::*;
#(
  parameter int  KEY_LEN = 4,
  parameter int  CNT_W   = 16,
  localparam int PTR_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load,
  input  logic [2*KEY_LEN-1:0]   key_i,
  input  logic                   resync,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [PTR_W-1:0]       key_ptr,
  output logic [CNT_W-1:0]       char_count,
  output logic                   err
);

  logic [2*KEY_LEN-1:0] key_r;
  logic [2*KEY_LEN-1:0] key_shift_s;
  logic [PTR_W-1:0]     ptr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 out_valid_r;
  logic [7:0]           out_data_r;
  logic [SETTING_W-1:0] setting_s;
  logic [7:0]           mem_out_s;
  logic                 accept_s;
  logic                 alpha_s;
  logic                 step_s;
  logic                 emit_s;

  // Slot 0 sits in the top bits, so shifting left by two per slot brings the active one to the top
  assign key_shift_s = key_r << {ptr_r, 1'b0};
  assign setting_s   = key_shift_s[2*KEY_LEN-1 -: SETTING_W];

  assign in_ready = (~out_valid_r | out_ready) & ~key_load & ~resync;
  assign accept_s = in_valid & in_ready;
  assign alpha_s  = is_alpha(in_data);
  assign step_s   = accept_s & alpha_s;

  mem_stream_decryptor_mem u_mem (
    .out     (mem_out_s),
    .in      (in_data),
    .setting (setting_s)
  );

`ifdef MEM_DEC_NONALPHA_PASS_EN
  assign emit_s = accept_s;
  assign err    = 1'b0;
`else
  logic err_r;

  assign emit_s = step_s;
  assign err    = err_r;

  // Flag each dropped non-letter for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept_s & ~alpha_s;
    end
  end
`endif

  // Output register, key register, pointer and saturating letter counter
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r       <= '0;
      ptr_r       <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      if (emit_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= mem_out_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end

      // key_load and resync block acceptance, so they never coincide with a step
      if (key_load) begin
        key_r <= key_i;
        ptr_r <= '0;
        cnt_r <= '0;
      end else if (resync) begin
        ptr_r <= '0;
      end else if (step_s) begin
        if (ptr_r == PTR_W'(KEY_LEN - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= ptr_r + PTR_W'(1);
        end
        if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign key_ptr    = ptr_r;
  assign char_count = cnt_r;

endmodule
